// File: rtl/timing_gen_pkg.sv
// Shared CPU constants for the beat/phase timing generator.
// Holds the beat and phase encodings, the ICNT width and the beat-sequencing rule.
package timing_gen_pkg;

    localparam int unsigned BEAT_W = 3;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned ICNT_W = 8;

    typedef enum logic [BEAT_W-1:0] {
        W1 = 3'b001,
        W2 = 3'b010,
        W3 = 3'b100
    } beat_e;

    typedef enum logic [PH_W-1:0] {
        PH_IDLE = 3'b000,
        PH_T1   = 3'b001,
        PH_T2   = 3'b010,
        PH_T3   = 3'b100
    } phase_e;

    // Beat that follows w at T3; SHORT only matters in W1 and LONG only in W2.
    function automatic beat_e next_beat(input beat_e w, input logic short_i, input logic long_i);
        beat_e nb;
        case (w)
            W1:      nb = short_i ? W1 : W2;
            W2:      nb = long_i ? W3 : W1;
            default: nb = W1;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/timing_gen_if.sv
// Controller-facing signal bundle of the timing generator.
interface timing_gen_if;
    import timing_gen_pkg::*;

    logic              QD;
    logic              DP;
    logic              SHORT;
    logic              LONG;
    logic              STOP;
    logic [PH_W-1:0]   T;
    logic [BEAT_W-1:0] W;
    logic              RUN;
    logic [ICNT_W-1:0] ICNT;

    modport master (output QD, DP, SHORT, LONG, STOP, input T, W, RUN, ICNT);
    modport slave  (input QD, DP, SHORT, LONG, STOP, output T, W, RUN, ICNT);

endinterface

// File: rtl/qd_sync.sv
// Start push-button synchronizer: two-flop sync followed by a registered rising-edge pulse.
module qd_sync (
    input  logic clk,
    input  logic rst,
    input  logic qd_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    always_comb begin
        sync1_d = qd_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller: T1-T2-T3 phases per beat,
// W1/W2/W3 beat stepping at T3, halt on STOP/DP and restart on a fresh QD edge.
module timing_gen
    import timing_gen_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    timing_gen_if.slave bus
);

    beat_e             w_q,    w_d;
    phase_e            t_q,    t_d;
    logic              run_q,  run_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    logic  start_c;
    logic  legal_c;
    beat_e w_nx_c;

    qd_sync u_qd_sync (
        .clk    (CLK),
        .rst    (RST),
        .qd_i   (bus.QD),
        .rise_o (start_c)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_q    <= W1;
            t_q    <= PH_IDLE;
            run_q  <= 1'b0;
            icnt_q <= '0;
        end else begin
            w_q    <= w_d;
            t_q    <= t_d;
            run_q  <= run_d;
            icnt_q <= icnt_d;
        end
    end

    // Start edges only count while halted, so an edge seen while running is simply dropped.
    always_comb begin
        w_d     = w_q;
        t_d     = t_q;
        run_d   = run_q;
        icnt_d  = icnt_q;
        w_nx_c  = next_beat(w_q, bus.SHORT, bus.LONG);
        legal_c = ((w_q == W1) || (w_q == W2) || (w_q == W3)) &&
                  (run_q == (t_q != PH_IDLE));

        if (!legal_c) begin
            w_d   = W1;
            t_d   = PH_IDLE;
            run_d = 1'b0;
        end else begin
            case (t_q)
                PH_IDLE: begin
                    if (start_c) begin
                        t_d   = PH_T1;
                        run_d = 1'b1;
                    end
                end
                PH_T1: t_d = PH_T2;
                PH_T2: t_d = PH_T3;
                PH_T3: begin
                    w_d = w_nx_c;
                    if (w_nx_c == W1) begin
                        icnt_d = icnt_q + ICNT_W'(1);
                    end
                    if (bus.STOP || bus.DP) begin
                        t_d   = PH_IDLE;
                        run_d = 1'b0;
                    end else begin
                        t_d = PH_T1;
                    end
                end
                default: begin
                    w_d   = W1;
                    t_d   = PH_IDLE;
                    run_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.T    = t_q;
    assign bus.W    = w_q;
    assign bus.RUN  = run_q;
    assign bus.ICNT = icnt_q;

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen: per-beat expectations go into a scoreboard queue
// when a beat's controller inputs are driven and are compared when that beat ends.
module tb_timing_gen;

    logic clk;
    logic rst;

    timing_gen_if bus();

    timing_gen dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] w;
        logic [2:0] t;
        logic       run;
        logic [7:0] icnt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] m_w    = 3'b001;
    logic [7:0] m_icnt = 8'd0;

    function automatic logic [2:0] model_next(input logic [2:0] w, input logic sh, input logic lg);
        if (w == 3'b001) return sh ? 3'b001 : 3'b010;
        if (w == 3'b010) return lg ? 3'b100 : 3'b001;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // c = {SHORT, LONG, STOP, DP} held for one beat
    task automatic push_exp(input logic [3:0] c);
        exp_t e;
        logic halt;
        m_w = model_next(m_w, c[3], c[2]);
        if (m_w == 3'b001) m_icnt = m_icnt + 8'd1;
        halt   = c[1] | c[0];
        e.w    = m_w;
        e.t    = halt ? 3'b000 : 3'b001;
        e.run  = ~halt;
        e.icnt = m_icnt;
        exp_q.push_back(e);
    endtask

    task automatic beat(input logic [3:0] c, output logic [2:0] ta, output logic [2:0] tb);
        {bus.SHORT, bus.LONG, bus.STOP, bus.DP} = c;
        tick();
        ta = bus.T;
        tick();
        tb = bus.T;
        tick();
        {bus.SHORT, bus.LONG, bus.STOP, bus.DP} = 4'b0000;
    endtask

    task automatic start(output int lat);
        bus.QD = 1'b0;
        repeat (3) tick();
        bus.QD = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) bus.QD = 1'b0;
            if (bus.T == 3'b001) begin
                lat = i;
                break;
            end
        end
        bus.QD = 1'b0;
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b1;
        {bus.QD, bus.SHORT, bus.LONG, bus.STOP, bus.DP} = 5'b00000;
        repeat (2) tick();
        checks++;
        if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== 15'b001_000_0_00000000) begin
            errors++;
            $display("FAIL reset_state: got W=%b T=%b RUN=%b ICNT=%0d want W=001 T=000 RUN=0 ICNT=0",
                     bus.W, bus.T, bus.RUN, bus.ICNT);
        end
        rst = 1'b0;
        act = 0;
        repeat (10) begin
            tick();
            if (bus.T !== 3'b000 || bus.RUN !== 1'b0) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d active cycles want 0", act);
        end
        m_w    = 3'b001;
        m_icnt = 8'd0;
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] tab [2] = '{4'b0000, 4'b0000};
        start(lat);
        checks++;
        if (lat < 1 || lat > 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles want 1..4", lat);
        end
        checks++;
        if (bus.W !== 3'b001 || bus.RUN !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_beat: got W=%b RUN=%b want W=001 RUN=1", bus.W, bus.RUN);
        end
        for (int i = 0; i < 2; i++) begin
            push_exp(tab[i]);
            beat(tab[i], ta, tb);
            e = exp_q.pop_front();
            checks++;
            if ({ta, tb} !== 6'b010_100) begin
                errors++;
                $display("FAIL basic_phases %0d: got T2=%b T3=%b want 010 100", i, ta, tb);
            end
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
                errors++;
                $display("FAIL basic_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                         i, bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
            end
        end
        checks++;
        if (bus.ICNT !== 8'd1) begin
            errors++;
            $display("FAIL basic_icnt: got %0d want 1", bus.ICNT);
        end
    endtask

    task automatic test_long();
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] tab [3] = '{4'b0100, 4'b0100, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            push_exp(tab[i]);
            beat(tab[i], ta, tb);
            e = exp_q.pop_front();
            checks++;
            if ({ta, tb} !== 6'b010_100) begin
                errors++;
                $display("FAIL long_phases %0d: got T2=%b T3=%b want 010 100", i, ta, tb);
            end
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
                errors++;
                $display("FAIL long_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                         i, bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
            end
        end
    endtask

    task automatic test_short();
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] tab [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            push_exp(tab[i]);
            beat(tab[i], ta, tb);
            e = exp_q.pop_front();
            checks++;
            if ({ta, tb} !== 6'b010_100) begin
                errors++;
                $display("FAIL short_phases %0d: got T2=%b T3=%b want 010 100", i, ta, tb);
            end
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
                errors++;
                $display("FAIL short_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                         i, bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
            end
        end
        // STOP only during T1 must not halt
        push_exp(4'b0000);
        bus.STOP = 1'b1;
        tick();
        bus.STOP = 1'b0;
        tick();
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
            errors++;
            $display("FAIL stop_in_t1: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                     bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
        end
    endtask

    task automatic test_stop();
        int lat, rises;
        logic prev_run;
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] tab [4] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                start(lat);
                checks++;
                if (lat < 1 || lat > 4 || bus.W !== m_w) begin
                    errors++;
                    $display("FAIL stop_resume: got lat=%0d W=%b want lat 1..4 W=%b", lat, bus.W, m_w);
                end
                bus.QD = 1'b1;
            end
            push_exp(tab[i]);
            beat(tab[i], ta, tb);
            bus.QD = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e || {ta, tb} !== 6'b010_100) begin
                errors++;
                $display("FAIL stop_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d T2=%b T3=%b want W=%b T=%b RUN=%b ICNT=%0d",
                         i, bus.W, bus.T, bus.RUN, bus.ICNT, ta, tb, e.w, e.t, e.run, e.icnt);
            end
            if (i == 1 || i == 3) begin
                repeat (8) tick();
                checks++;
                if ({bus.W, bus.T, bus.RUN} !== {m_w, 3'b000, 1'b0}) begin
                    errors++;
                    $display("FAIL stop_held %0d: got W=%b T=%b RUN=%b want W=%b T=000 RUN=0",
                             i, bus.W, bus.T, bus.RUN, m_w);
                end
            end
        end
        // QD held for 20 cycles with STOP high: one start, one beat
        push_exp(4'b0010);
        bus.QD   = 1'b1;
        bus.STOP = 1'b1;
        rises    = 0;
        prev_run = bus.RUN;
        repeat (20) begin
            tick();
            if (bus.RUN === 1'b1 && prev_run !== 1'b1) rises++;
            prev_run = bus.RUN;
        end
        bus.QD   = 1'b0;
        bus.STOP = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL held_qd_starts: got %0d starts want 1", rises);
        end
        checks++;
        if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
            errors++;
            $display("FAIL held_qd_state: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                     bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
        end
    endtask

    task automatic test_dp();
        int lat;
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] tab [3] = '{4'b0001, 4'b0001, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            start(lat);
            checks++;
            if (lat < 1 || lat > 4) begin
                errors++;
                $display("FAIL dp_latency %0d: got %0d cycles want 1..4", i, lat);
            end
            push_exp(tab[i]);
            beat(tab[i], ta, tb);
            e = exp_q.pop_front();
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e || {ta, tb} !== 6'b010_100) begin
                errors++;
                $display("FAIL dp_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d T2=%b T3=%b want W=%b T=%b RUN=%b ICNT=%0d",
                         i, bus.W, bus.T, bus.RUN, bus.ICNT, ta, tb, e.w, e.t, e.run, e.icnt);
            end
            repeat (4) tick();
            checks++;
            if (bus.RUN !== 1'b0 || bus.T !== 3'b000) begin
                errors++;
                $display("FAIL dp_single %0d: got RUN=%b T=%b want RUN=0 T=000", i, bus.RUN, bus.T);
            end
        end
    endtask

    task automatic test_wrap();
        int lat;
        exp_t e;
        logic [2:0] ta, tb;
        logic [3:0] c;
        start(lat);
        checks++;
        if (lat < 1 || lat > 4) begin
            errors++;
            $display("FAIL wrap_latency: got %0d cycles want 1..4", lat);
        end
        for (int n = 0; n < 700 && m_icnt != 8'd255; n++) begin
            c = (m_w == 3'b001) ? 4'b1000 : 4'b0000;
            push_exp(c);
            beat(c, ta, tb);
            e = exp_q.pop_front();
            checks++;
            if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e) begin
                errors++;
                $display("FAIL wrap_beat %0d: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=%0d",
                         n, bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run, e.icnt);
            end
        end
        checks++;
        if (bus.ICNT !== 8'd255) begin
            errors++;
            $display("FAIL wrap_preload: got %0d want 255", bus.ICNT);
        end
        push_exp(4'b1010);
        beat(4'b1010, ta, tb);
        e = exp_q.pop_front();
        checks++;
        if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== e || bus.ICNT !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got W=%b T=%b RUN=%b ICNT=%0d want W=%b T=%b RUN=%b ICNT=0",
                     bus.W, bus.T, bus.RUN, bus.ICNT, e.w, e.t, e.run);
        end
    endtask

    task automatic test_reset_mid();
        int lat, act;
        exp_t e;
        logic [2:0] ta, tb;
        start(lat);
        push_exp(4'b0000);
        beat(4'b0000, ta, tb);
        e = exp_q.pop_front();
        tick();
        checks++;
        if (lat < 1 || lat > 4 || bus.W !== e.w || bus.T !== 3'b010) begin
            errors++;
            $display("FAIL rmid_setup: got lat=%0d W=%b T=%b want lat 1..4 W=%b T=010", lat, bus.W, bus.T, e.w);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.W, bus.T, bus.RUN, bus.ICNT} !== 15'b001_000_0_00000000) begin
            errors++;
            $display("FAIL rmid_async: got W=%b T=%b RUN=%b ICNT=%0d want W=001 T=000 RUN=0 ICNT=0",
                     bus.W, bus.T, bus.RUN, bus.ICNT);
        end
        m_w    = 3'b001;
        m_icnt = 8'd0;
        tick();
        rst = 1'b0;
        act = 0;
        repeat (10) begin
            tick();
            if (bus.T !== 3'b000 || bus.RUN !== 1'b0 || bus.ICNT !== 8'd0) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL rmid_idle: got %0d active cycles want 0", act);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long();
        test_short();
        test_stop();
        test_dp();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 The module SHALL be a beat/phase timing generator sitting directly upstream of the hardwired controller: it produces the W[3:1] beats and the T3 phase that the controller consumes, and it consumes the controller's SHORT, LONG and STOP outputs.
REQ-002 CLK  input  1  system clock, rising-edge; the only clock.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 QD  input  1  start push-button level; asynchronous to CLK.
REQ-005 DP  input  1  single-beat mode (1 = halt after every beat).
REQ-006 SHORT  input  1  from the controller; current instruction has a single beat.
REQ-007 LONG  input  1  from the controller; current instruction needs beat W3.
REQ-008 STOP  input  1  from the controller; halt at the end of the current beat.
REQ-009 T  output  3  one-hot phase; T[1]=T1, T[2]=T2, T[3]=T3; 000 while halted.
REQ-010 W  output  3  one-hot beat, W[3:1]; always exactly one bit set.
REQ-011 RUN  output  1  1 while phases are being generated.
REQ-012 ICNT  output  8  completed-instruction count, for debug.

Function
REQ-013 Sequencing: while RUN=1, T SHALL cycle T1->T2->T3->T1, with one CLK cycle per phase.
REQ-014 Sampling: SHORT, LONG, STOP and DP SHALL be sampled only in the cycle where T3=1; W SHALL change on the edge that ends T3.
REQ-015 Beat transitions, evaluated at T3:
- W1 with SHORT=1 -> W1.
- W1 with SHORT=0 -> W2.
- W2 with LONG=1 -> W3.
- W2 with LONG=0 -> W1.
- W3 -> W1 unconditionally.
REQ-016 SHORT sampled in W2 or W3, and LONG sampled in W1 or W3, SHALL be ignored.
REQ-017 Halt: if STOP=1 or DP=1 at T3, the beat transition of REQ-015 SHALL still occur, RUN SHALL go 0 and T SHALL go 000 on the same edge.
REQ-018 Start: a rising edge of synchronized QD while RUN=0 SHALL set RUN=1 and T=001 on the next edge; W is unchanged.
REQ-019 Start latency: at most 4 CLK cycles from the QD input to T1, comprising a 2-flop synchronizer, the edge-detect register and the start edge.
REQ-020 QD edges while RUN=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 A held QD SHALL produce exactly one start.
REQ-022 ICNT SHALL increment by 1, modulo 256 (255 -> 0), on every T3 edge whose next beat is W1, including SHORT W1 -> W1.
REQ-023 When STOP and DP are asserted together, the result SHALL be identical to either one alone.
REQ-024 STOP arriving in T1 or T2 SHALL have no effect until T3.
REQ-025 Illegal W or T encodings SHALL recover to W=001, T=000, RUN=0 on the next edge.

Reset
REQ-026 RST=1 SHALL asynchronously force W=001, T=000, RUN=0, ICNT=0, and clear the synchronizer and edge-detect flops.
REQ-027 A reset mid-beat SHALL abandon the beat; no partial T3 or ICNT increment SHALL occur.
REQ-028 After RST is released the block SHALL stay halted until a fresh QD rising edge.

Structure
REQ-029 The beat encodings (W1=001, W2=010, W3=100), the phase encodings, and the ICNT width SHALL be constants in the shared CPU package.
REQ-030 QD synchronization and rising-edge detection SHALL be one sub-module, qd_sync (2-flop synchronizer plus edge pulse); everything else SHALL be flat in timing_gen.

Verification
REQ-031 Reset, then pulse QD -> T1 within 4 cycles, W=001; with SHORT=LONG=STOP=0, W sequence 001,010,001 with 3 cycles per beat; ICNT=1 after the first W2 T3.
REQ-032 LONG=1 held during W2 T3 -> W=100 next; then W=001; ICNT increments once for the whole 3-beat instruction.
REQ-033 SHORT=1 during W1 T3 -> W stays 001, ICNT increments every 3 cycles; pulsing STOP during T1 only -> no halt.
REQ-034 STOP=1 at W1 T3 -> RUN=0, T=000, W=010 held; QD toggled again -> resumes at T1 with W=010; QD held high for 20 cycles -> only one restart.
REQ-035 DP=1 -> exactly one beat (3 T-cycles) per QD edge; preload ICNT=255 -> wraps to 0.
REQ-036 RST asserted during W2 T2 -> immediate W=001, T=000, RUN=0, ICNT=0; no further T activity without QD.
